// File: rtl/dma_pkg.sv
// Shared definitions for the SDRAM DMA engines: state encoding, Avalon constants and
// default widths.
package dma_pkg;

  localparam int unsigned DMA_ADDR_W  = 29;
  localparam int unsigned DMA_SRC_AW  = 10;
  localparam int unsigned DMA_SRC_DW  = 48;
  localparam int unsigned DMA_SRC_LAT = 1;

  // Single-beat, full-width writes only
  localparam logic [7:0] DMA_BURST = 8'd1;
  localparam logic [7:0] DMA_BE    = 8'hFF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLatch = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_to_sdram.sv
// Write-direction DMA: copies a frame from local dist RAM into SDRAM, one zero-extended
// word per single-beat Avalon-MM write.
// Optional macro DMA_TO_SDRAM_ABORT_EN adds an abort input that ends the transfer early.
module dma_to_sdram
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W  = DMA_ADDR_W,
  parameter int unsigned SRC_AW  = DMA_SRC_AW,
  parameter int unsigned SRC_DW  = DMA_SRC_DW,
  parameter int unsigned SRC_LAT = DMA_SRC_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] begin_address,
  input  logic [31:0]       size_buffer,
  output logic              busy,
  output logic              done,
  output logic [SRC_AW-1:0] src_address,
  input  logic [SRC_DW-1:0] src_data,
  output logic [ADDR_W-1:0] sdram0_data_address,
  output logic              sdram0_data_write,
  output logic [63:0]       sdram0_data_writedata,
  output logic [7:0]        sdram0_data_byteenable,
  output logic [7:0]        sdram0_data_burstcount,
`ifdef DMA_TO_SDRAM_ABORT_EN
  input  logic              abort,
`endif
  input  logic              sdram0_data_waitrequest
);

  localparam int unsigned LatW = (SRC_LAT > 1) ? $clog2(SRC_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(SRC_LAT - 1);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [63:0]       writedata_q, writedata_d;
  logic [SRC_AW-1:0] src_address_q, src_address_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       size_q, size_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic              abort_pend_q, abort_pend_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_in;

`ifdef DMA_TO_SDRAM_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // Next-state and datapath updates for the fetch/latch/write sequence
  always_comb begin
    state_d       = state_q;
    address_d     = address_q;
    writedata_d   = writedata_q;
    src_address_d = src_address_q;
    count_d       = count_q;
    size_d        = size_q;
    lat_d         = lat_q;
    abort_pend_d  = abort_pend_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          address_d     = begin_address;
          size_d        = size_buffer;
          src_address_d = '0;
          count_d       = '0;
          lat_d         = '0;
          abort_pend_d  = 1'b0;
          state_d       = (size_buffer == 32'd0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (abort_in) begin
          lat_d   = '0;
          state_d = StDone;
        end else if (lat_q == LatLast) begin
          lat_d   = '0;
          state_d = StLatch;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StLatch: begin
        if (abort_in) begin
          state_d = StDone;
        end else begin
          writedata_d = 64'(src_data);
          state_d     = StWrite;
        end
      end
      StWrite: begin
        // Abort cannot cut a held Avalon write short; remember it until acceptance
        if (abort_in) begin
          abort_pend_d = 1'b1;
        end
        if (!sdram0_data_waitrequest) begin
          count_d       = count_q + 32'd1;
          address_d     = address_q + ADDR_W'(1);
          src_address_d = src_address_q + SRC_AW'(1);
          if ((count_q + 32'd1 == size_q) || abort_in || abort_pend_q) begin
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    write_d = (state_d == StWrite);
    busy_d  = (state_d != StIdle);
    // Pulse lands as busy drops, so a new start is taken in the same cycle as done
    done_d  = (state_q == StDone);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      address_q     <= '0;
      writedata_q   <= '0;
      src_address_q <= '0;
      count_q       <= '0;
      size_q        <= '0;
      lat_q         <= '0;
      abort_pend_q  <= 1'b0;
      write_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      address_q     <= address_d;
      writedata_q   <= writedata_d;
      src_address_q <= src_address_d;
      count_q       <= count_d;
      size_q        <= size_d;
      lat_q         <= lat_d;
      abort_pend_q  <= abort_pend_d;
      write_q       <= write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign src_address            = src_address_q;
  assign sdram0_data_address    = address_q;
  assign sdram0_data_write      = write_q;
  assign sdram0_data_writedata  = writedata_q;
  assign sdram0_data_byteenable = DMA_BE;
  assign sdram0_data_burstcount = DMA_BURST;

endmodule

// File: tb/tb_dma_to_sdram.sv
// Scoreboard bench for dma_to_sdram: stimulus pushes expected writes, a monitor pops and
// compares on every accepted Avalon write.
module tb_dma_to_sdram;

  localparam int unsigned AW  = 29;
  localparam int unsigned SAW = 10;
  localparam int unsigned SDW = 48;
  localparam int unsigned LAT = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [AW-1:0]  begin_address;
  logic [31:0]    size_buffer;
  logic           busy;
  logic           done;
  logic [SAW-1:0] src_address;
  logic [SDW-1:0] src_data;
  logic [AW-1:0]  av_address;
  logic           av_write;
  logic [63:0]    av_writedata;
  logic [7:0]     av_byteenable;
  logic [7:0]     av_burstcount;
  logic           av_waitrequest;
  logic           abort;

  logic [SDW-1:0] mem [1024];

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int n_done = 0;
  int hold_cnt = 0;
  logic [AW-1:0] hold_addr;
  logic [63:0]   hold_data;

  logic [AW-1:0] exp_addr_q[$];
  logic [63:0]   exp_data_q[$];
  int            hold_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Dist RAM model, one cycle read latency
  always @(posedge clk) src_data <= mem[src_address];

  dma_to_sdram #(
    .ADDR_W (AW),
    .SRC_AW (SAW),
    .SRC_DW (SDW),
    .SRC_LAT(LAT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .begin_address          (begin_address),
    .size_buffer            (size_buffer),
    .busy                   (busy),
    .done                   (done),
    .src_address            (src_address),
    .src_data               (src_data),
    .sdram0_data_address    (av_address),
    .sdram0_data_write      (av_write),
    .sdram0_data_writedata  (av_writedata),
    .sdram0_data_byteenable (av_byteenable),
    .sdram0_data_burstcount (av_burstcount),
`ifdef DMA_TO_SDRAM_ABORT_EN
    .abort                  (abort),
`endif
    .sdram0_data_waitrequest(av_waitrequest)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on acceptance, hold-stability while waitrequest is high
  initial begin
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (av_write) begin
        if (hold_cnt == 0) begin
          hold_addr = av_address;
          hold_data = av_writedata;
        end else begin
          check("hold_addr", 64'(av_address), 64'(hold_addr));
          check("hold_data", av_writedata, hold_data);
        end
        hold_cnt++;
        if (!av_waitrequest) begin
          n_writes++;
          hold_q.push_back(hold_cnt);
          hold_cnt = 0;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual_addr=0x%0h required=none", av_address);
          end else begin
            check("wr_addr", 64'(av_address), 64'(exp_addr_q.pop_front()));
            check("wr_data", av_writedata, exp_data_q.pop_front());
          end
        end
      end else begin
        hold_cnt = 0;
      end
    end
  end

  task automatic push_words(input logic [AW-1:0] a, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_addr_q.push_back(a + AW'(i));
      exp_data_q.push_back(64'((i % 1024) + 1));
    end
  endtask

  task automatic wait_done(input int unsigned budget, output bit seen, output int unsigned dcyc);
    seen = 1'b0;
    dcyc = 0;
    for (int unsigned k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  task automatic run_xfer(input logic [AW-1:0] a, input int unsigned n, input bit chk_lat);
    bit seen;
    int unsigned dcyc;
    int unsigned scyc;
    push_words(a, n);
    n_writes = 0;
    n_done   = 0;
    @(posedge clk); #1;
    begin_address = a;
    size_buffer   = n;
    start         = 1'b1;
    scyc          = cyc;
    @(posedge clk); #1;
    check("busy_after_start", 64'(busy), 64'd1);
    // Changes after start, and a start while busy, must be ignored
    begin_address = '1;
    size_buffer   = 32'd7;
    start         = (n != 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n * (LAT + 2) + 60, seen, dcyc);
    if (seen) begin
      if (chk_lat) check("done_latency", 64'(dcyc - scyc), 64'(n * (LAT + 2) + 2));
      check("busy_at_done", 64'(busy), 64'd0);
      check("src_addr_end", 64'(src_address), 64'(n % 1024));
    end
    repeat (3) @(negedge clk);
    check("done_count", 64'(n_done), 64'd1);
    check("write_count", 64'(n_writes), 64'(n));
    check("sb_empty", 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit got;
    for (int i = 0; i < 1024; i++) mem[i] = SDW'(i + 1);
    rst            = 1'b1;
    start          = 1'b0;
    begin_address  = '0;
    size_buffer    = '0;
    av_waitrequest = 1'b0;
    abort          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_write", 64'(av_write), 64'd0);
    check("rst_addr", 64'(av_address), 64'd0);
    check("rst_wdata", av_writedata, 64'd0);
    check("rst_src_addr", 64'(src_address), 64'd0);
    check("byteenable", 64'(av_byteenable), 64'hFF);
    check("burstcount", 64'(av_burstcount), 64'd1);
    rst = 1'b0;

    // 1: four words, no backpressure, 3 cycles per word
    run_xfer(29'h100, 4, 1'b1);

    // 2: waitrequest held 5 cycles on word 0
    hold_q.delete();
    av_waitrequest = 1'b1;
    fork
      run_xfer(29'h200, 2, 1'b0);
      begin
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
          @(negedge clk);
          if (av_write) got = 1'b1;
        end
        if (!got) $display("FAIL first_write_timeout actual=no_write required=write");
        repeat (5) @(posedge clk);
        #1 av_waitrequest = 1'b0;
      end
    join
    check("hold_entries", 64'(hold_q.size()), 64'd2);
    if (hold_q.size() == 2) begin
      check("hold_word0", 64'(hold_q[0]), 64'd6);
      check("hold_word1", 64'(hold_q[1]), 64'd1);
    end

    // 3: zero-length transfer
    run_xfer(29'h80, 0, 1'b1);

    // 4: SDRAM address wrap, then src_address wrap
    run_xfer(29'h1FFFFFFF, 2, 1'b1);
    run_xfer(29'h300, 1026, 1'b1);

    // 5: async reset while a write is held
    av_waitrequest = 1'b1;
    @(posedge clk); #1;
    begin_address = 29'h400;
    size_buffer   = 32'd3;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (av_write) got = 1'b1;
    end
    check("rst_test_write_seen", 64'(got), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_write", 64'(av_write), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_addr", 64'(av_address), 64'd0);
    @(posedge clk); #1;
    rst            = 1'b0;
    av_waitrequest = 1'b0;
    run_xfer(29'h40, 2, 1'b1);

`ifdef DMA_TO_SDRAM_ABORT_EN
    // 6: abort during the held write of word 1 of 8
    begin
      bit seen;
      int unsigned dcyc;
      push_words(29'h500, 2);
      n_writes = 0;
      n_done   = 0;
      @(posedge clk); #1;
      begin_address = 29'h500;
      size_buffer   = 32'd8;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      got   = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (av_write && av_address == 29'h501) got = 1'b1;
      end
      check("abort_word1_seen", 64'(got), 64'd1);
      abort          = 1'b1;
      av_waitrequest = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(posedge clk); #1;
      av_waitrequest = 1'b0;
      wait_done(40, seen, dcyc);
      repeat (3) @(negedge clk);
      check("abort_done_count", 64'(n_done), 64'd1);
      check("abort_write_count", 64'(n_writes), 64'd2);
      check("abort_sb_empty", 64'(exp_addr_q.size()), 64'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
